// File: rtl/result_uart_tx_if.sv
// result_uart_tx_if: core result/state feed into result_uart_tx and its UART status back out.
interface result_uart_tx_if #(parameter int DATA_W = 64);
    logic              clk_enable;
    logic [3:0]        state_in;
    logic [DATA_W-1:0] result_in;
    logic              tx;
    logic              busy;
    logic [15:0]       dropped_count;
    modport master (output clk_enable, state_in, result_in, input tx, busy, dropped_count);
    modport slave  (input clk_enable, state_in, result_in, output tx, busy, dropped_count);
endinterface

// File: rtl/result_uart_tx.sv
// result_uart_tx: streams each completed SUBLEQ result as an ASCII hex line over 8N1 UART.
// Optional RESULT_UART_CHANGE_ONLY_EN: skip frames whose result equals the last one sent.
module result_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_W       = 64
) (
    input logic             clk,
    input logic             rst,
    result_uart_tx_if.slave bus
);
    localparam int NDIG   = DATA_W / 4;
    localparam int NBYTES = NDIG + 2;
    localparam int CW     = $clog2(CLKS_PER_BIT);
    localparam int BW     = $clog2(NBYTES);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;
    localparam logic [3:0] UPDATE_PC = 4'd12;

    logic [1:0]        state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [2:0]        bit_idx, bit_n;
    logic [BW-1:0]     byte_idx, byte_n;
    logic [DATA_W-1:0] cap;
    logic [3:0]        nib;
    logic [7:0]        cur_byte;
    logic              trig, accept, drop, tick, tx_n;

    assign trig = bus.state_in == UPDATE_PC && bus.clk_enable;
    assign drop = trig && state != IDLE;
    assign tick = cnt == CW'(CLKS_PER_BIT - 1);
    assign bus.busy = state != IDLE;

`ifdef RESULT_UART_CHANGE_ONLY_EN
    logic [DATA_W-1:0] last_sent;
    logic              last_valid;
    assign accept = trig && state == IDLE && !(last_valid && bus.result_in == last_sent);
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            last_sent  <= '0;
            last_valid <= 1'b0;
        end else if (accept) begin
            last_sent  <= bus.result_in;
            last_valid <= 1'b1;
        end
`else
    assign accept = trig && state == IDLE;
`endif

    // Byte is looked up for the next cycle so tx can be a clean register output.
    assign nib      = 4'(cap >> (4 * (NDIG - 1 - int'(byte_n))));
    assign cur_byte = int'(byte_n) < NDIG ? (nib < 4'd10 ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib})
                    : int'(byte_n) == NDIG ? 8'h0D : 8'h0A;
    assign tx_n     = state_n == START ? 1'b0 : state_n == DATA ? cur_byte[bit_n] : 1'b1;

    always_comb begin
        state_n = state;
        cnt_n   = tick ? '0 : cnt + 1'b1;
        bit_n   = bit_idx;
        byte_n  = byte_idx;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (accept) begin
                    state_n = START;
                    byte_n  = '0;
                end
            end
            START: if (tick) begin
                state_n = DATA;
                bit_n   = '0;
            end
            DATA: if (tick) begin
                state_n = bit_idx == 3'd7 ? STOP : DATA;
                bit_n   = bit_idx + 1'b1;
            end
            default: if (tick) begin
                state_n = int'(byte_idx) == NBYTES - 1 ? IDLE : START;
                byte_n  = byte_idx + 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state             <= IDLE;
            cnt               <= '0;
            bit_idx           <= '0;
            byte_idx          <= '0;
            cap               <= '0;
            bus.tx            <= 1'b1;
            bus.dropped_count <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_idx  <= bit_n;
            byte_idx <= byte_n;
            bus.tx   <= tx_n;
            if (accept) cap <= bus.result_in;
            if (drop && bus.dropped_count != 16'hFFFF) bus.dropped_count <= bus.dropped_count + 16'd1;
        end
endmodule
